dp_ram_be: RTL and testbench

- Parametrised 1-write/1-read dual-port RAM. Successor to the fixed 32x8 dual-port RAM.
- Generalised in width and depth, with per-byte write enables and a selectable read-during-write policy.
- Selectable 1- or 2-cycle read latency, with a read-valid strobe aligned to the data.
- Built-in clear sequencer zeroes the whole array after every reset, so contents are defined without a testbench preload.
- Sits between verification traffic generators and the scoreboard models as the team's general-purpose on-chip buffer.

---
 rtl/dp_ram_be.sv | 231 +++++++++++++++++++++++
 tb/tb_dp_ram_be.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_be.sv
// ---------------------------------------------------------------------------
// dp_ram_be : parametrised 1-write / 1-read dual-port RAM with byte enables.
//
// Zeroes the whole array after every reset with a built-in clear sweep.
// Read latency is 1 or 2 cycles, and the read-during-write policy is
// selectable.
//
// Parameters
//   ADDR_W   : address width, DEPTH = 2**ADDR_W words
//   DATA_W   : data width, multiple of 8, NB = DATA_W/8 byte lanes
//   RD_LAT   : read latency in cycles (1 or 2)
//   RDW_MODE : same-address read-during-write, 0 = old data, 1 = new (merged)
//
// Ports
//   clk, rst           : clock, async active-high reset
//   wr_en/wr_be        : write request, per-lane write enables
//   wr_addr/w_data     : write address and data
//   rd_en/rd_addr      : read request and address
//   r_data/rd_valid    : read data and its one-cycle valid strobe
//   init_done          : clear sweep finished, requests accepted
//   perr_inj           : invert stored parity of lanes written this cycle
//   rd_perr            : per-lane parity error, aligned with rd_valid
//
// Optional feature
//   Define DP_RAM_PARITY_EN to store one even-parity bit per lane.
//   Without it, perr_inj is ignored and rd_perr is always 0.
// ---------------------------------------------------------------------------
module dp_ram_be #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned RDW_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     w_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     r_data,
    output logic                  rd_valid,
    output logic                  init_done,
    input  logic                  perr_inj,
    output logic [DATA_W/8-1:0]   rd_perr
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned NB    = DATA_W / 8;

    // Elaboration-time parameter checks
    if (DATA_W % 8 != 0) begin : g_bad_data_w
        $error("dp_ram_be: DATA_W (%0d) must be a multiple of 8", DATA_W);
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
        $error("dp_ram_be: RD_LAT (%0d) must be 1 or 2", RD_LAT);
    end

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   clr_cnt;

    logic                clr_we_c;
    logic                wr_acc_c;
    logic                rd_acc_c;
    logic                init_done_nxt_c;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                rdw_hit_c;
    logic [DATA_W-1:0]   rd_old_c;
    logic [DATA_W-1:0]   rd_word_c;
    logic [NB-1:0]       rd_perr_c;

    logic [DATA_W-1:0]   s1_data;
    logic [NB-1:0]       s1_perr;
    logic                s1_valid;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: the sweep ends after the last address is cleared
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR: if (clr_cnt == ADDR_W'(DEPTH - 1)) state_nxt = READY;
            READY: state_nxt = READY;
            default: state_nxt = CLEAR;
        endcase
    end

    // FSM outputs: clear strobe and request gating
    always_comb begin
        clr_we_c        = 1'b0;
        wr_acc_c        = 1'b0;
        rd_acc_c        = 1'b0;
        init_done_nxt_c = 1'b0;
        case (state)
            CLEAR: clr_we_c = 1'b1;
            READY: begin
                wr_acc_c = wr_en;
                rd_acc_c = rd_en;
            end
            default: clr_we_c = 1'b1;
        endcase
        init_done_nxt_c = (state_nxt == READY);
    end

    // Clear address counter and init_done flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt   <= '0;
            init_done <= 1'b0;
        end else begin
            if (clr_we_c) clr_cnt <= clr_cnt + ADDR_W'(1);
            init_done <= init_done_nxt_c;
        end
    end

    // Data array: the clear sweep has priority, user writes are per lane
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem[clr_cnt] <= '0;
        end else if (wr_acc_c) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wr_be[i]) mem[wr_addr][8*i +: 8] <= w_data[8*i +: 8];
            end
        end
    end

    // Read mux: in write-through mode, enabled lanes of a colliding write bypass the array
    always_comb begin
        rd_old_c  = mem[rd_addr];
        rd_word_c = rd_old_c;
        rdw_hit_c = (RDW_MODE == 1) && wr_acc_c && (wr_addr == rd_addr);
        if (rdw_hit_c) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wr_be[i]) rd_word_c[8*i +: 8] = w_data[8*i +: 8];
            end
        end
    end

`ifdef DP_RAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];

    // Parity array: even parity per lane, inverted on injected writes
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            par_mem[clr_cnt] <= '0;
        end else if (wr_acc_c) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (wr_be[i]) par_mem[wr_addr][i] <= (^w_data[8*i +: 8]) ^ perr_inj;
            end
        end
    end

    // Parity recheck; bypassed lanes carry fresh data and never flag
    always_comb begin
        rd_perr_c = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            if (!(rdw_hit_c && wr_be[i])) begin
                rd_perr_c[i] = (^rd_old_c[8*i +: 8]) ^ par_mem[rd_addr][i];
            end
        end
    end
`else
    logic unused_perr_inj;
    assign unused_perr_inj = perr_inj;

    always_comb begin
        rd_perr_c = '0;
    end
`endif

    // First read stage; data holds when no read is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_data  <= '0;
            s1_perr  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= rd_acc_c;
            if (rd_acc_c) begin
                s1_data <= rd_word_c;
                s1_perr <= rd_perr_c;
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] s2_data;
        logic [NB-1:0]     s2_perr;
        logic              s2_valid;

        // Second read stage, advanced only by a completing first stage
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s2_data  <= '0;
                s2_perr  <= '0;
                s2_valid <= 1'b0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                    s2_perr <= s1_perr;
                end
            end
        end

        assign r_data   = s2_data;
        assign rd_perr  = s2_perr;
        assign rd_valid = s2_valid;
    end else begin : g_lat1
        assign r_data   = s1_data;
        assign rd_perr  = s1_perr;
        assign rd_valid = s1_valid;
    end

endmodule

// File: tb/tb_dp_ram_be.sv
// ---------------------------------------------------------------------------
// tb_dp_ram_be : scoreboard bench for dp_ram_be.
// It instantiates two copies with shared inputs:
//   a = RD_LAT 1, RDW_MODE 0 (old data)
//   b = RD_LAT 2, RDW_MODE 1 (write-through)
// The bench keeps a reference memory model. Each accepted read pushes its
// expected result onto that copy's queue. A negedge monitor checks the
// result on its due cycle.
// ---------------------------------------------------------------------------
module tb_dp_ram_be;

`ifdef DP_RAM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  p;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_be = '0;
    logic [4:0]  wr_addr = '0;
    logic [15:0] w_data = '0;
    logic        rd_en = 1'b0;
    logic [4:0]  rd_addr = '0;
    logic        perr_inj = 1'b0;

    logic [15:0] r_data_w    [2];
    logic        rd_valid_w  [2];
    logic        init_done_w [2];
    logic [1:0]  rd_perr_w   [2];

    logic [15:0] mdl   [32];
    logic [1:0]  mperr [32];
    bit          ready_mdl = 1'b0;
    int          cyc = 0;
    exp_t        q [2][$];
    logic [15:0] last_d [2];

    int n_tests = 0;
    int n_fail  = 0;

    dp_ram_be #(.ADDR_W(5), .DATA_W(16), .RD_LAT(1), .RDW_MODE(0)) u_dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
        .w_data(w_data), .rd_en(rd_en), .rd_addr(rd_addr), .r_data(r_data_w[0]),
        .rd_valid(rd_valid_w[0]), .init_done(init_done_w[0]), .perr_inj(perr_inj),
        .rd_perr(rd_perr_w[0])
    );

    dp_ram_be #(.ADDR_W(5), .DATA_W(16), .RD_LAT(2), .RDW_MODE(1)) u_dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_be(wr_be), .wr_addr(wr_addr),
        .w_data(w_data), .rd_en(rd_en), .rd_addr(rd_addr), .r_data(r_data_w[1]),
        .rd_valid(rd_valid_w[1]), .init_done(init_done_w[1]), .perr_inj(perr_inj),
        .rd_perr(rd_perr_w[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    // Scoreboard monitor, sampling away from the active edge
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            string pfx;
            bit    ev;
            exp_t  e;
            pfx = (k == 0) ? "a" : "b";
            ev  = 1'b0;
            while (q[k].size() > 0 && q[k][0].due < cyc) begin
                check({pfx, "_rd_missing"}, 32'd0, 32'd1);
                void'(q[k].pop_front());
            end
            if (q[k].size() > 0 && q[k][0].due == cyc) ev = 1'b1;
            check({pfx, "_rd_valid"}, 32'(rd_valid_w[k]), 32'(ev));
            if (ev) begin
                e = q[k].pop_front();
                check({pfx, "_r_data"}, 32'(r_data_w[k]), 32'(e.d));
                check({pfx, "_rd_perr"}, 32'(rd_perr_w[k]), 32'(e.p));
                last_d[k] = e.d;
            end else begin
                check({pfx, "_r_data_hold"}, 32'(r_data_w[k]), 32'(last_d[k]));
            end
        end
    end

    task automatic cyc_step();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus; expectations come from the model's pre-write contents
    task automatic drive(input bit we, input logic [1:0] be, input logic [4:0] wa,
                         input logic [15:0] wd, input bit inj, input bit re,
                         input logic [4:0] ra);
        exp_t e;
        wr_en = we; wr_be = be; wr_addr = wa; w_data = wd; perr_inj = inj;
        rd_en = re; rd_addr = ra;
        if (ready_mdl && re) begin
            for (int k = 0; k < 2; k++) begin
                e.due = cyc + lat_of(k);
                e.d   = mdl[ra];
                e.p   = mperr[ra];
                if (k == 1 && we && wa == ra) begin
                    for (int i = 0; i < 2; i++) begin
                        if (be[i]) begin
                            e.d[8*i +: 8] = wd[8*i +: 8];
                            e.p[i]        = 1'b0;
                        end
                    end
                end
                q[k].push_back(e);
            end
        end
        if (ready_mdl && we) begin
            for (int i = 0; i < 2; i++) begin
                if (be[i]) begin
                    mdl[wa][8*i +: 8] = wd[8*i +: 8];
                    mperr[wa][i]      = PAR & inj;
                end
            end
        end
        cyc_step();
        wr_en = 1'b0; rd_en = 1'b0; perr_inj = 1'b0; wr_be = '0;
    endtask

    // Asynchronous reset assertion: pending reads are dropped, outputs clear at once
    task automatic assert_rst();
        rst = 1'b1;
        ready_mdl = 1'b0;
        q[0].delete();
        q[1].delete();
        last_d[0] = '0;
        last_d[1] = '0;
        #1;
        for (int k = 0; k < 2; k++) begin
            string pfx;
            pfx = (k == 0) ? "a" : "b";
            check({pfx, "_rst_r_data"}, 32'(r_data_w[k]), 32'd0);
            check({pfx, "_rst_rd_valid"}, 32'(rd_valid_w[k]), 32'd0);
            check({pfx, "_rst_init_done"}, 32'(init_done_w[k]), 32'd0);
            check({pfx, "_rst_rd_perr"}, 32'(rd_perr_w[k]), 32'd0);
        end
    endtask

    // Release reset and follow the sweep; abort_at > 0 re-asserts reset mid-sweep
    task automatic release_and_init(input int abort_at);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            if (i == 20) drive(1'b1, 2'b11, 5'h03, 16'h00A5, 1'b0, 1'b1, 5'h03);
            else         cyc_step();
            check("a_init_done_sweep", 32'(init_done_w[0]), 32'(i == 32));
            check("b_init_done_sweep", 32'(init_done_w[1]), 32'(i == 32));
            if (i == abort_at) begin
                #2;
                assert_rst();
                return;
            end
        end
        for (int a = 0; a < 32; a++) begin
            mdl[a]   = '0;
            mperr[a] = '0;
        end
        ready_mdl = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset for 3 cycles, then the full sweep with an ignored pre-init write
        assert_rst();
        repeat (3) cyc_step();
        release_and_init(0);

        // Every word reads back zero, back-to-back
        for (int a = 0; a < 32; a++) drive(1'b0, 2'b00, 5'h00, 16'h0000, 1'b0, 1'b1, 5'(a));

        // Byte-lane merge
        drive(1'b1, 2'b11, 5'h05, 16'h1234, 1'b0, 1'b0, 5'h00);
        drive(1'b1, 2'b01, 5'h05, 16'hABCD, 1'b0, 1'b0, 5'h00);
        drive(1'b0, 2'b00, 5'h00, 16'h0000, 1'b0, 1'b1, 5'h05);
        drive(1'b1, 2'b00, 5'h05, 16'hFFFF, 1'b0, 1'b0, 5'h00);
        drive(1'b0, 2'b00, 5'h00, 16'h0000, 1'b0, 1'b1, 5'h05);

        // Read-during-write on the same address, then a follow-up read
        drive(1'b1, 2'b11, 5'h07, 16'h1111, 1'b0, 1'b0, 5'h00);
        drive(1'b1, 2'b10, 5'h07, 16'h2222, 1'b0, 1'b1, 5'h07);
        drive(1'b0, 2'b00, 5'h00, 16'h0000, 1'b0, 1'b1, 5'h07);

        // Parity inject and clean rewrite
        drive(1'b1, 2'b01, 5'h09, 16'h00FF, 1'b1, 1'b0, 5'h00);
        drive(1'b0, 2'b00, 5'h00, 16'h0000, 1'b0, 1'b1, 5'h09);
        drive(1'b1, 2'b01, 5'h09, 16'h00FF, 1'b0, 1'b1, 5'h09);
        drive(1'b0, 2'b00, 5'h00, 16'h0000, 1'b0, 1'b1, 5'h09);
        repeat (3) drive(1'b0, 2'b00, 5'h00, 16'h0000, 1'b0, 1'b0, 5'h00);

        // Reset while reads are in flight
        drive(1'b0, 2'b00, 5'h00, 16'h0000, 1'b0, 1'b1, 5'h05);
        drive(1'b0, 2'b00, 5'h00, 16'h0000, 1'b0, 1'b1, 5'h05);
        #2;
        assert_rst();
        cyc_step();
        release_and_init(0);
        drive(1'b0, 2'b00, 5'h00, 16'h0000, 1'b0, 1'b1, 5'h05);

        // Reset mid-sweep; the restarted sweep must take the full 32 cycles
        repeat (3) drive(1'b0, 2'b00, 5'h00, 16'h0000, 1'b0, 1'b0, 5'h00);
        #2;
        assert_rst();
        release_and_init(10);
        cyc_step();
        release_and_init(0);

        // Random traffic over a narrow address window to force collisions
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
                  16'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)));
        end

        repeat (4) drive(1'b0, 2'b00, 5'h00, 16'h0000, 1'b0, 1'b0, 5'h00);
        check("queue_drained", 32'(q[0].size() + q[1].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
